interrupt_entry_unit: RTL

- Sequencer upstream of fetch_stage: converts an external interrupt request into a hardware CALL.
- Freezes fetch, drains in-flight instructions, pushes return PC then flags through the memory-stage stack port, reads the ISR address from the vector slot, and loads it into the PC.
- Inserts NOPs into decode while busy. Tracks "in ISR" until the RTI retires.

---
 rtl/interrupt_entry_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/interrupt_entry_unit.sv
// rtl/interrupt_entry_unit.sv - interrupt entry sequencer (hardware CALL); optional nesting via INT_NESTING_EN
module interrupt_entry_unit #(
  parameter int                DATA_W          = 16,
  parameter int                FLAG_W          = 3,
  parameter logic [DATA_W-1:0] INT_VECTOR_ADDR = '0,
  parameter int                DRAIN_CYCLES    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              rti_done,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_freeze,
  output logic              insert_nop,
  output logic              mem_req,
  output logic              mem_push,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_load_value,
  output logic              flags_clear,
  output logic              int_active
);

  // The counter holds the drain cycles still to spend after the current one,
  // so DRAIN lasts DRAIN_CYCLES cycles, and one cycle when DRAIN_CYCLES is 0.
  localparam int CNT_W      = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, LOAD_VEC, JUMP
  } state_t;

  state_t            state, state_nxt;
  logic              int_q;
  logic              pending;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ret_pc;
  logic [FLAG_W-1:0] saved_flags;
  logic [DATA_W-1:0] vec;
  logic              int_rise;
  logic              accept;
  logic              take;

  assign int_rise = int_in & ~int_q;
  assign take     = (state == IDLE) && pending && accept;

`ifdef INT_NESTING_EN
  logic [1:0] depth;
  logic       depth_dec;

  assign depth_dec  = rti_done && (depth != 2'd0);
  assign accept     = (depth != 2'd3);
  assign int_active = (depth != 2'd0);

  // Nesting depth: JUMP opens a level, a retiring RTI closes one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth <= 2'd0;
    end else begin
      case ({state == JUMP, depth_dec})
        2'b10:   depth <= depth + 2'd1;
        2'b01:   depth <= depth - 2'd1;
        default: depth <= depth;
      endcase
    end
  end
`else
  logic active_q;

  assign accept     = !active_q;
  assign int_active = active_q;

  // Single-level ISR flag: set by JUMP, cleared by a retiring RTI
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
    end else if (state == JUMP) begin
      active_q <= 1'b1;
    end else if (rti_done) begin
      active_q <= 1'b0;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Edge sync, pending latch, drain counter and captured context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_q       <= 1'b0;
      pending     <= 1'b0;
      cnt         <= '0;
      ret_pc      <= '0;
      saved_flags <= '0;
      vec         <= '0;
    end else begin
      int_q   <= int_in;
      pending <= (pending & ~take) | int_rise;
      if (take) begin
        ret_pc <= pc_in;
        cnt    <= CNT_W'(DRAIN_LOAD);
      end else if ((state == DRAIN) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if ((state == DRAIN) && (cnt == '0)) begin
        saved_flags <= flags_in;
      end
      if ((state == LOAD_VEC) && mem_ack) begin
        vec <= mem_rdata;
      end
    end
  end

  // Next-state logic; memory states wait for mem_ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (take) state_nxt = DRAIN;
      DRAIN:      if (cnt == '0) state_nxt = PUSH_PC;
      PUSH_PC:    if (mem_ack) state_nxt = PUSH_FLAGS;
      PUSH_FLAGS: if (mem_ack) state_nxt = LOAD_VEC;
      LOAD_VEC:   if (mem_ack) state_nxt = JUMP;
      JUMP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so at most one memory request per cycle
  always_comb begin
    fetch_freeze  = (state != IDLE);
    insert_nop    = (state != IDLE);
    mem_req       = 1'b0;
    mem_push      = 1'b0;
    mem_read      = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    flags_clear   = 1'b0;
    case (state)
      PUSH_PC: begin
        mem_req   = 1'b1;
        mem_push  = 1'b1;
        mem_wdata = ret_pc;
      end
      PUSH_FLAGS: begin
        mem_req   = 1'b1;
        mem_push  = 1'b1;
        mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, saved_flags};
      end
      LOAD_VEC: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        mem_addr = INT_VECTOR_ADDR;
      end
      JUMP: begin
        pc_load       = 1'b1;
        pc_load_value = vec;
        flags_clear   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
